// File: rtl/gate_truth_checker.sv
// Clocked stimulus/compare stage for a 2-input gate: walks idx 0..3, samples dut_out, checks against TRUTH.
// Optional first-mismatch capture ports enabled by GATE_TRUTH_CHECKER_ERR_CAPTURE_EN.
module gate_truth_checker #(
  parameter logic [3:0]  TRUTH  = 4'b0111,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       in0,
  output logic       in1,
  output logic       busy,
  output logic       done,
  output logic       pass,
`ifdef GATE_TRUTH_CHECKER_ERR_CAPTURE_EN
  output logic       first_err_valid,
  output logic [1:0] first_err_idx,
`endif
  output logic [2:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       mismatch_s;
  logic       fv_q, fv_d;
  logic [1:0] fi_q, fi_d;

  // Next-state, counters and result bookkeeping
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    pass_d     = pass_q;
    fv_d       = fv_q;
    fi_d       = fi_q;
    mismatch_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          idx_d   = 2'd0;
          cnt_d   = SETTLE_L;
          err_d   = 3'd0;
          pass_d  = 1'b0;
          fv_d    = 1'b0;
          fi_d    = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_SAMPLE;
        end else begin
          state_d = S_DRIVE;
        end
      end
      S_SAMPLE: begin
        mismatch_s = (dut_out != TRUTH[idx_q]);
        if (mismatch_s && (err_q != 3'd4)) begin
          err_d = err_q + 3'd1;
        end else begin
          err_d = err_q;
        end
        // Only the first mismatch of a run is captured
        if (mismatch_s && !fv_q) begin
          fv_d = 1'b1;
          fi_d = idx_q;
        end else begin
          fv_d = fv_q;
        end
        if (idx_q == 2'd3) begin
          state_d = S_DONE;
          pass_d  = (err_d == 3'd0);
        end else begin
          state_d = S_DRIVE;
          idx_d   = idx_q + 2'd1;
          cnt_d   = SETTLE_L;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      err_q   <= 3'd0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fv_q    <= 1'b0;
      fi_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fv_q    <= fv_d;
      fi_q    <= fi_d;
    end
  end

  assign in0       = idx_q[0];
  assign in1       = idx_q[1];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

`ifdef GATE_TRUTH_CHECKER_ERR_CAPTURE_EN
  assign first_err_valid = fv_q;
  assign first_err_idx   = fi_q;
`else
  logic unused_fe_s;
  assign unused_fe_s = fv_q ^ fi_q[0] ^ fi_q[1];
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: NAND instance (SETTLE=2) with selectable faulty gate, XOR instance (SETTLE=1).
module tb_gate_truth_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start_x;
  logic [1:0] mode;
  logic       dut_out, dut_out_x;
  logic       in0, in1, busy, done, pass;
  logic       in0_x, in1_x, busy_x, done_x, pass_x;
  logic [2:0] err_count, err_count_x;
`ifdef GATE_TRUTH_CHECKER_ERR_CAPTURE_EN
  logic       fv, fv_x;
  logic [1:0] fi, fi_x;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Gate models: 0 good NAND, 1 stuck-1, 2 stuck-0, 3 AND (all wrong)
  always_comb begin
    case (mode)
      2'd0:    dut_out = ~(in0 & in1);
      2'd1:    dut_out = 1'b1;
      2'd2:    dut_out = 1'b0;
      default: dut_out = in0 & in1;
    endcase
  end
  assign dut_out_x = in0_x ^ in1_x;

  gate_truth_checker #(.TRUTH(4'b0111), .SETTLE(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out),
    .in0(in0), .in1(in1), .busy(busy), .done(done), .pass(pass),
`ifdef GATE_TRUTH_CHECKER_ERR_CAPTURE_EN
    .first_err_valid(fv), .first_err_idx(fi),
`endif
    .err_count(err_count)
  );

  gate_truth_checker #(.TRUTH(4'b0110), .SETTLE(1)) u_dut_x (
    .clk(clk), .rst(rst), .start(start_x), .dut_out(dut_out_x),
    .in0(in0_x), .in1(in1_x), .busy(busy_x), .done(done_x), .pass(pass_x),
`ifdef GATE_TRUTH_CHECKER_ERR_CAPTURE_EN
    .first_err_valid(fv_x), .first_err_idx(fi_x),
`endif
    .err_count(err_count_x)
  );

  typedef struct {
    logic [1:0] mode;
    logic       exp_pass;
    logic [2:0] exp_err;
    logic [1:0] exp_fidx;
    logic       exp_fvalid;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full run on the NAND instance; start is driven in cycle 0
  task automatic run_one(input int k);
    int done_cyc, n_done, busy_bad, in_bad;
    done_cyc = -1; n_done = 0; busy_bad = 0; in_bad = 0;
    mode  = vecs[k].mode;
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      start = 1'b0;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy != ((c >= 1) && (c <= 12))) busy_bad++;
      if ((c <= 12) && ({30'd0, in1, in0} != (c - 1) / 3)) in_bad++;
    end
    chk($sformatf("v%0d done_cycle", k), done_cyc, 13);
    chk($sformatf("v%0d done_pulses", k), n_done, 1);
    chk($sformatf("v%0d busy_window", k), busy_bad, 0);
    chk($sformatf("v%0d in_sequence", k), in_bad, 0);
    chk($sformatf("v%0d pass", k), pass, vecs[k].exp_pass);
    chk($sformatf("v%0d err_count", k), err_count, vecs[k].exp_err);
`ifdef GATE_TRUTH_CHECKER_ERR_CAPTURE_EN
    chk($sformatf("v%0d first_err_valid", k), fv, vecs[k].exp_fvalid);
    if (vecs[k].exp_fvalid) chk($sformatf("v%0d first_err_idx", k), fi, vecs[k].exp_fidx);
`endif
  endtask

  initial begin
    int n_done, d1, d2, busy_bad, in_bad;

    vecs[0] = '{mode: 2'd0, exp_pass: 1'b1, exp_err: 3'd0, exp_fidx: 2'd0, exp_fvalid: 1'b0};
    vecs[1] = '{mode: 2'd1, exp_pass: 1'b0, exp_err: 3'd1, exp_fidx: 2'd3, exp_fvalid: 1'b1};
    vecs[2] = '{mode: 2'd2, exp_pass: 1'b0, exp_err: 3'd3, exp_fidx: 2'd0, exp_fvalid: 1'b1};
    vecs[3] = '{mode: 2'd3, exp_pass: 1'b0, exp_err: 3'd4, exp_fidx: 2'd0, exp_fvalid: 1'b1};

    rst = 1'b1; start = 1'b0; start_x = 1'b0; mode = 2'd0;
    step(); step();
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst pass", pass, 0);
    chk("rst err_count", err_count, 0);
    chk("rst in", {in1, in0}, 0);
    chk("rst x busy", busy_x, 0);
    rst = 1'b0;
    step();

    for (int k = 0; k < 4; k++) run_one(k);

    // Extra start pulses at cycles 5 and 13 must be ignored
    mode = 2'd0; start = 1'b1; n_done = 0; d1 = -1; busy_bad = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      start = (c == 5) || (c == 13);
      if (done) begin n_done++; if (d1 < 0) d1 = c; end
      if ((c >= 14) && busy) busy_bad++;
    end
    chk("ignore_start done_pulses", n_done, 1);
    chk("ignore_start done_cycle", d1, 13);
    chk("ignore_start no_rerun", busy_bad, 0);

    // start held high: second run accepted on the IDLE cycle after DONE
    start = 1'b1; d1 = -1; d2 = -1;
    for (int c = 1; c <= 28; c++) begin
      step();
      if (c == 14) chk("held busy@14", busy, 0);
      if (c == 15) chk("held busy@15", busy, 1);
      if (done) begin if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c; end
      if (c == 27) start = 1'b0;
    end
    chk("held done1", d1, 13);
    chk("held done2", d2, 27);
    step();

    // rst mid-run at cycle 7
    start = 1'b1; n_done = 0;
    for (int c = 1; c <= 7; c++) begin
      step();
      start = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst busy", busy, 0);
    chk("midrst in", {in1, in0}, 0);
    chk("midrst err_count", err_count, 0);
    chk("midrst pass", pass, 0);
    chk("midrst done", done, 0);
    for (int c = 9; c <= 25; c++) begin
      step();
      if (done || busy) n_done++;
    end
    chk("midrst no_resume", n_done, 0);

    // rst and start together: start not accepted
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk("rst_start busy", busy, 0);
    step();
    chk("rst_start busy2", busy, 0);

    run_one(0);

    // XOR gate, SETTLE=1: two cycles per vector, done at cycle 9
    start_x = 1'b1; d1 = -1; n_done = 0; busy_bad = 0; in_bad = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      start_x = 1'b0;
      if (done_x) begin n_done++; if (d1 < 0) d1 = c; end
      if (busy_x != ((c >= 1) && (c <= 8))) busy_bad++;
      if ((c <= 8) && ({30'd0, in1_x, in0_x} != (c - 1) / 2)) in_bad++;
    end
    chk("xor done_cycle", d1, 9);
    chk("xor done_pulses", n_done, 1);
    chk("xor busy_window", busy_bad, 0);
    chk("xor in_sequence", in_bad, 0);
    chk("xor pass", pass_x, 1);
    chk("xor err_count", err_count_x, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
